calc_multiport: RTL and testbench

Synthesisable, parametrised successor to the four-port calculator. NUM_CH independent request channels share one arithmetic unit (ADD/SUB) and one shift unit (LSH/RSH). Each unit serves one request per cycle, with round-robin arbitration across channels. The block adds overflow/underflow detection and immediate invalid-command responses, and sits between the port request interface and the response bus.

---
 rtl/calc_multiport_if.sv | 29 ++
 rtl/calc_multiport.sv | 204 ++++++++++++++++++++
 tb/tb_calc_multiport.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/calc_multiport_if.sv
// Request/response bundle for calc_multiport: per-channel command and operand in,
// per-channel response code, result and busy flag out.
interface calc_multiport_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CMD_W  = 4
);
    logic [NUM_CH*CMD_W-1:0]  req_cmd_in;
    logic [NUM_CH*DATA_W-1:0] req_data_in;
    logic [NUM_CH*2-1:0]      out_resp;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic [NUM_CH-1:0]        busy;

    modport master (
        output req_cmd_in,
        output req_data_in,
        input  out_resp,
        input  out_data,
        input  busy
    );

    modport slave (
        input  req_cmd_in,
        input  req_data_in,
        output out_resp,
        output out_data,
        output busy
    );
endinterface

// File: rtl/calc_multiport.sv
// Multi-channel calculator: NUM_CH request FSMs share one ADD/SUB unit and one LSH/RSH unit,
// each round-robin arbitrated. Define CALC_MULTIPORT_SHIFT_OVF_EN to flag lossy shifts.
module calc_multiport #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CMD_W  = 4
) (
    input logic             c_clk,
    input logic             reset,
    calc_multiport_if.slave bus
);

    localparam int unsigned PtrW = $clog2(NUM_CH);
    localparam int unsigned ShW  = $clog2(DATA_W);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StOp2  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    localparam logic [1:0] RespOk  = 2'd1;
    localparam logic [1:0] RespErr = 2'd2;
    localparam logic [1:0] RespInt = 2'd3;

    localparam logic [CMD_W-1:0] CmdNop = CMD_W'(0);
    localparam logic [CMD_W-1:0] CmdAdd = CMD_W'(1);
    localparam logic [CMD_W-1:0] CmdSub = CMD_W'(2);
    localparam logic [CMD_W-1:0] CmdLsh = CMD_W'(5);
    localparam logic [CMD_W-1:0] CmdRsh = CMD_W'(6);

    logic [1:0]        state_q [NUM_CH];
    logic [1:0]        state_d [NUM_CH];
    logic [CMD_W-1:0]  cmd_q   [NUM_CH];
    logic [CMD_W-1:0]  cmd_d   [NUM_CH];
    logic [DATA_W-1:0] op1_q   [NUM_CH];
    logic [DATA_W-1:0] op1_d   [NUM_CH];
    logic [DATA_W-1:0] op2_q   [NUM_CH];
    logic [DATA_W-1:0] op2_d   [NUM_CH];
    logic [1:0]        resp_q  [NUM_CH];
    logic [1:0]        resp_d  [NUM_CH];
    logic [DATA_W-1:0] data_q  [NUM_CH];
    logic [DATA_W-1:0] data_d  [NUM_CH];

    logic [PtrW-1:0]   a_ptr_q, a_ptr_d, s_ptr_q, s_ptr_d;
    logic [NUM_CH-1:0] is_arith, is_shift, a_req, s_req;
    logic              a_found, s_found;
    logic [PtrW-1:0]   a_win, s_win;
    logic [DATA_W-1:0] a_x, a_y, a_res, s_x, s_res;
    logic [DATA_W:0]   a_sum;
    logic [ShW-1:0]    s_amt;
    logic [1:0]        a_resp, s_resp;
`ifdef CALC_MULTIPORT_SHIFT_OVF_EN
    logic              s_lossy;
`endif

    // First requester at or after ptr, wrapping modulo NUM_CH.
    function automatic void rr_pick(input logic [NUM_CH-1:0] req, input logic [PtrW-1:0] ptr,
                                    output logic found, output logic [PtrW-1:0] win);
        int idx;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            idx = int'(ptr) + i;
            if (idx >= int'(NUM_CH)) idx = idx - int'(NUM_CH);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PtrW'(idx);
            end
        end
    endfunction

    function automatic logic [PtrW-1:0] ptr_after(input logic [PtrW-1:0] win);
        return (win == PtrW'(NUM_CH - 1)) ? '0 : win + 1'b1;
    endfunction

    always_comb begin
        for (int k = 0; k < int'(NUM_CH); k++) begin
            is_arith[k] = (cmd_q[k] == CmdAdd) || (cmd_q[k] == CmdSub);
            is_shift[k] = (cmd_q[k] == CmdLsh) || (cmd_q[k] == CmdRsh);
            a_req[k]    = (state_q[k] == StWait) && is_arith[k];
            s_req[k]    = (state_q[k] == StWait) && is_shift[k];
        end
    end

    always_comb begin
        rr_pick(a_req, a_ptr_q, a_found, a_win);
        rr_pick(s_req, s_ptr_q, s_found, s_win);
        a_ptr_d = a_found ? ptr_after(a_win) : a_ptr_q;
        s_ptr_d = s_found ? ptr_after(s_win) : s_ptr_q;
    end

    always_comb begin
        a_x    = op1_q[a_win];
        a_y    = op2_q[a_win];
        a_sum  = {1'b0, a_x} + {1'b0, a_y};
        a_resp = RespOk;
        a_res  = '0;
        if (cmd_q[a_win] == CmdAdd) begin
            if (a_sum[DATA_W]) a_resp = RespErr;
            else               a_res  = a_sum[DATA_W-1:0];
        end else begin
            if (a_x < a_y) a_resp = RespErr;
            else           a_res  = a_x - a_y;
        end
    end

    always_comb begin
        s_x    = op1_q[s_win];
        s_amt  = op2_q[s_win][ShW-1:0];
        s_resp = RespOk;
        s_res  = (cmd_q[s_win] == CmdLsh) ? (s_x << s_amt) : (s_x >> s_amt);
`ifdef CALC_MULTIPORT_SHIFT_OVF_EN
        // Undoing the shift recovers the operand only if no 1 bit fell off.
        s_lossy = (cmd_q[s_win] == CmdLsh) ? ((s_res >> s_amt) != s_x)
                                           : ((s_res << s_amt) != s_x);
        if (s_lossy) begin
            s_resp = RespErr;
            s_res  = '0;
        end
`endif
    end

    always_comb begin
        for (int k = 0; k < int'(NUM_CH); k++) begin
            state_d[k] = state_q[k];
            cmd_d[k]   = cmd_q[k];
            op1_d[k]   = op1_q[k];
            op2_d[k]   = op2_q[k];
            resp_d[k]  = '0;
            data_d[k]  = '0;
            unique case (state_q[k])
                StIdle, StResp: begin
                    if (bus.req_cmd_in[k*CMD_W +: CMD_W] != CmdNop) begin
                        cmd_d[k]   = bus.req_cmd_in[k*CMD_W +: CMD_W];
                        op1_d[k]   = bus.req_data_in[k*DATA_W +: DATA_W];
                        state_d[k] = StOp2;
                    end else begin
                        state_d[k] = StIdle;
                    end
                end
                StOp2: begin
                    op2_d[k] = bus.req_data_in[k*DATA_W +: DATA_W];
                    if (is_arith[k] || is_shift[k]) begin
                        state_d[k] = StWait;
                    end else begin
                        state_d[k] = StResp;
                        resp_d[k]  = RespErr;
                    end
                end
                default: begin
                    if (!is_arith[k] && !is_shift[k]) begin
                        state_d[k] = StIdle;
                        resp_d[k]  = RespInt;
                    end else if (a_found && a_req[k] && (a_win == PtrW'(k))) begin
                        state_d[k] = StResp;
                        resp_d[k]  = a_resp;
                        data_d[k]  = a_res;
                    end else if (s_found && s_req[k] && (s_win == PtrW'(k))) begin
                        state_d[k] = StResp;
                        resp_d[k]  = s_resp;
                        data_d[k]  = s_res;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            a_ptr_q <= '0;
            s_ptr_q <= '0;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                state_q[k] <= StIdle;
                cmd_q[k]   <= '0;
                op1_q[k]   <= '0;
                op2_q[k]   <= '0;
                resp_q[k]  <= '0;
                data_q[k]  <= '0;
            end
        end else begin
            a_ptr_q <= a_ptr_d;
            s_ptr_q <= s_ptr_d;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                state_q[k] <= state_d[k];
                cmd_q[k]   <= cmd_d[k];
                op1_q[k]   <= op1_d[k];
                op2_q[k]   <= op2_d[k];
                resp_q[k]  <= resp_d[k];
                data_q[k]  <= data_d[k];
            end
        end
    end

    for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_ch
        assign bus.out_resp[k*2 +: 2]          = resp_q[k];
        assign bus.out_data[k*DATA_W +: DATA_W] = data_q[k];
        assign bus.busy[k]                      = (state_q[k] != StIdle);

        // OP2 filters unknown commands, so a WAIT channel always has a valid class.
        a_wait_class: assert property (@(posedge c_clk) disable iff (reset)
            (state_q[k] == StWait) |-> (is_arith[k] || is_shift[k]));
    end

endmodule

// File: tb/tb_calc_multiport.sv
// Directed bench for calc_multiport (NUM_CH=4, DATA_W=32, CMD_W=4).
module tb_calc_multiport;

    localparam int unsigned NumCh = 4;
    localparam int unsigned DataW = 32;
    localparam int unsigned CmdW  = 4;

`ifdef CALC_MULTIPORT_SHIFT_OVF_EN
    localparam logic [31:0] LshOvfResp = 32'd2;
`else
    localparam logic [31:0] LshOvfResp = 32'd1;
`endif

    logic c_clk = 1'b0;
    logic reset;
    int   n_err    = 0;
    int   n_checks = 0;

    calc_multiport_if #(.NUM_CH(NumCh), .DATA_W(DataW), .CMD_W(CmdW)) bus ();

    calc_multiport #(.NUM_CH(NumCh), .DATA_W(DataW), .CMD_W(CmdW)) dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 c_clk = ~c_clk;

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    task automatic drive(input int ch, input logic [3:0] cmd, input logic [31:0] data);
        bus.req_cmd_in[ch*4 +: 4]    = cmd;
        bus.req_data_in[ch*32 +: 32] = data;
    endtask

    function automatic logic [31:0] resp_of(input int ch);
        return 32'(bus.out_resp[ch*2 +: 2]);
    endfunction

    function automatic logic [31:0] data_of(input int ch);
        return bus.out_data[ch*32 +: 32];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with random inputs
        reset = 1'b1;
        bus.req_cmd_in  = 16'($urandom);
        bus.req_data_in = {$urandom, $urandom, $urandom, $urandom};
        step();
        bus.req_cmd_in  = 16'($urandom);
        bus.req_data_in = {$urandom, $urandom, $urandom, $urandom};
        step();
        for (int ch = 0; ch < 4; ch++) begin
            check("rst_resp", resp_of(ch), 32'd0);
            check("rst_data", data_of(ch), 32'd0);
        end
        check("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        bus.req_cmd_in  = '0;
        bus.req_data_in = '0;
        step();
        check("idle_busy", 32'(bus.busy), 32'd0);

        // ADD ok on ch0, ADD overflow on ch1 (ch1 waits one cycle behind ch0)
        drive(0, 4'd1, 32'd5);
        drive(1, 4'd1, 32'hFFFF_FFFF);
        step();
        check("add_busy", 32'(bus.busy), 32'h3);
        drive(0, 4'd0, 32'd3);
        drive(1, 4'd0, 32'd1);
        step();
        check("add_t2_resp0", resp_of(0), 32'd0);
        step();
        check("add_resp0", resp_of(0), 32'd1);
        check("add_data0", data_of(0), 32'd8);
        check("add_t3_resp1", resp_of(1), 32'd0);
        step();
        check("add_resp0_gone", resp_of(0), 32'd0);
        check("ovf_resp1", resp_of(1), 32'd2);
        check("ovf_data1", data_of(1), 32'd0);

        // SUB underflow on ch2, invalid cmd 4 on ch3
        drive(2, 4'd2, 32'd3);
        drive(3, 4'd4, 32'd0);
        step();
        drive(2, 4'd0, 32'd5);
        drive(3, 4'd0, 32'd9);
        step();
        check("inv_resp3", resp_of(3), 32'd2);
        check("inv_data3", data_of(3), 32'd0);
        check("sub_t2_resp2", resp_of(2), 32'd0);
        step();
        check("sub_resp2", resp_of(2), 32'd2);
        check("sub_data2", data_of(2), 32'd0);
        check("inv_resp3_gone", resp_of(3), 32'd0);
        check("sub_busy", 32'(bus.busy), 32'h4);
        step();

        // Contention: pointers back to 0, two identical rounds of 4 ADDs
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) drive(k, 4'd1, 32'(k * 16));
            step();
            for (int k = 0; k < 4; k++) drive(k, 4'd0, 32'd1);
            step();
            for (int k = 0; k < 4; k++) begin
                step();
                check("rr_resp", 32'(bus.out_resp), 32'(8'h01 << (2 * k)));
                check("rr_data", data_of(k), 32'(k * 16 + 1));
            end
        end

        // ADD on ch0 and LSH on ch1 served in the same cycle
        drive(0, 4'd1, 32'd2);
        drive(1, 4'd5, 32'd1);
        step();
        drive(0, 4'd0, 32'd3);
        drive(1, 4'd0, 32'h24);
        step();
        step();
        check("conc_resp", 32'(bus.out_resp), 32'h05);
        check("conc_data0", data_of(0), 32'd5);
        check("conc_data1", data_of(1), 32'h10);
        step();

        // RSH on ch2, lossy LSH on ch3 (shift unit serves ch2 first)
        drive(2, 4'd6, 32'h8000_0000);
        drive(3, 4'd5, 32'h8000_0000);
        step();
        drive(2, 4'd0, 32'd31);
        drive(3, 4'd0, 32'd1);
        step();
        step();
        check("rsh_resp2", resp_of(2), 32'd1);
        check("rsh_data2", data_of(2), 32'd1);
        check("lsh_wait3", resp_of(3), 32'd0);
        step();
        check("lshovf_resp3", resp_of(3), LshOvfResp);
        check("lshovf_data3", data_of(3), 32'd0);
        step();

        // Back-to-back on ch0: new ADD issued in the RESP cycle
        drive(0, 4'd1, 32'd7);
        step();
        drive(0, 4'd0, 32'd8);
        step();
        step();
        check("b2b_resp_a", resp_of(0), 32'd1);
        check("b2b_data_a", data_of(0), 32'd15);
        drive(0, 4'd1, 32'h100);
        step();
        check("b2b_gap1", resp_of(0), 32'd0);
        drive(0, 4'd0, 32'h11);
        step();
        check("b2b_gap2", resp_of(0), 32'd0);
        step();
        check("b2b_resp_b", resp_of(0), 32'd1);
        check("b2b_data_b", data_of(0), 32'h111);
        step();

        // Reset while ch1 is in WAIT
        drive(1, 4'd1, 32'd1);
        step();
        drive(1, 4'd0, 32'd1);
        step();
        check("mid_busy", 32'(bus.busy), 32'h2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_resp1", resp_of(1), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        drive(1, 4'd1, 32'd4);
        step();
        check("post_rst_busy", 32'(bus.busy), 32'h2);
        check("post_rst_resp1", resp_of(1), 32'd0);
        drive(1, 4'd0, 32'd5);
        step();
        check("post_rst_wait", resp_of(1), 32'd0);
        step();
        check("post_rst_resp", resp_of(1), 32'd1);
        check("post_rst_data", data_of(1), 32'd9);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
